// File: rtl/bht_predictor_pkg.sv
// bht_predictor_pkg: shared frontend types for the branch history table.
package bht_predictor_pkg;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } bht_entry_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

endpackage

// File: rtl/bht_sat_ctr.sv
// bht_sat_ctr: next-state of one BHT entry for a resolved branch direction.
module bht_sat_ctr
    import bht_predictor_pkg::*;
(
    input  bht_entry_t cur,
    input  logic       taken,
    output bht_entry_t nxt
);

    always_comb begin
        nxt.valid = 1'b1;
        nxt.ctr   = !cur.valid ? (taken ? 2'b10 : 2'b01) :
                    taken      ? ((cur.ctr == 2'b11) ? 2'b11 : cur.ctr + 2'b01) :
                                 ((cur.ctr == 2'b00) ? 2'b00 : cur.ctr - 2'b01);
    end

endmodule

// File: rtl/bht_predictor.sv
// bht_predictor: 2-bit counter branch history table, one prediction per fetch slot.
// Optional global history row hashing enabled by defining BHT_GLOBAL_HIST_EN.
module bht_predictor
    import bht_predictor_pkg::*;
#(
    parameter int unsigned VLEN            = 64,
    parameter int unsigned BHTEntries      = 128,
    parameter int unsigned BHTHist         = 3,
    parameter int unsigned INSTR_PER_FETCH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic                       lookup_valid_i,
    input  logic [VLEN-1:0]            vpc_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    input  logic                       update_valid_i,
    input  logic [VLEN-1:0]            update_pc_i,
    input  logic                       update_taken_i
);

    localparam int unsigned ROWS     = BHTEntries / INSTR_PER_FETCH;
    localparam int unsigned ROW_BITS = $clog2(ROWS);
    localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);

    bht_entry_t                           bht_q [ROWS][INSTR_PER_FETCH];
    bht_prediction_t [INSTR_PER_FETCH-1:0] pred_q;
    bht_entry_t                           upd_entry;
    logic [ROW_BITS-1:0]                  hist_row, lookup_row, update_row;
    logic [COL_BITS-1:0]                  update_col;
    logic                                 train, unused_bits;

    assign train      = update_valid_i && !debug_mode_i && !flush_i;
    assign lookup_row = vpc_i[1+COL_BITS +: ROW_BITS] ^ hist_row;
    assign update_row = update_pc_i[1+COL_BITS +: ROW_BITS] ^ hist_row;
    assign update_col = update_pc_i[1 +: COL_BITS];

    // Offset bits and tag bits above the row take no part in indexing.
    assign unused_bits = ^{vpc_i[VLEN-1:1+COL_BITS+ROW_BITS], vpc_i[COL_BITS:0],
                           update_pc_i[VLEN-1:1+COL_BITS+ROW_BITS], update_pc_i[0]};

`ifdef BHT_GLOBAL_HIST_EN
    logic [BHTHist-1:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) hist_q <= '0;
        else if (train) hist_q <= BHTHist'({hist_q, update_taken_i});
    end

    assign hist_row = ROW_BITS'(hist_q);
`else
    assign hist_row = '0;
`endif

    bht_sat_ctr u_ctr (
        .cur   (bht_q[update_row][update_col]),
        .taken (update_taken_i),
        .nxt   (upd_entry)
    );

    // Lookup samples the table before this edge's write: read-before-write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < INSTR_PER_FETCH; c++)
                    bht_q[r][c] <= '0;
            pred_q <= '0;
        end else begin
            if (flush_i) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < INSTR_PER_FETCH; c++)
                        bht_q[r][c].valid <= 1'b0;
            end else if (train) begin
                bht_q[update_row][update_col] <= upd_entry;
            end
            for (int c = 0; c < INSTR_PER_FETCH; c++)
                pred_q[c] <= (lookup_valid_i && !flush_i) ?
                    bht_prediction_t'{valid: bht_q[lookup_row][c].valid,
                                      taken: bht_q[lookup_row][c].ctr[1]} :
                    bht_prediction_t'('0);
        end
    end

    for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_out
        assign pred_valid_o[i] = pred_q[i].valid;
        assign pred_taken_o[i] = pred_q[i].taken;
    end

endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: directed self-checking bench for bht_predictor.
module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        debug_mode_i = 1'b0;
    logic        lookup_valid_i = 1'b0;
    logic [63:0] vpc_i = '0;
    logic [1:0]  pred_valid_o, pred_taken_o;
    logic        update_valid_i = 1'b0;
    logic [63:0] update_pc_i = '0;
    logic        update_taken_i = 1'b0;
    int          tests = 0;
    int          fails = 0;

    bht_predictor dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .debug_mode_i   (debug_mode_i),
        .lookup_valid_i (lookup_valid_i),
        .vpc_i          (vpc_i),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .update_valid_i (update_valid_i),
        .update_pc_i    (update_pc_i),
        .update_taken_i (update_taken_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [63:0] pc, input logic t);
        update_valid_i = 1'b1;
        update_pc_i    = pc;
        update_taken_i = t;
        tick();
        update_valid_i = 1'b0;
    endtask

    task automatic look(input logic [63:0] pc);
        lookup_valid_i = 1'b1;
        vpc_i          = pc;
        tick();
        lookup_valid_i = 1'b0;
    endtask

    task automatic chk_v(input string tag, input logic [1:0] ev);
        tests++;
        assert (pred_valid_o === ev) else begin
            fails++;
            $error("FAIL %s valid: observed %b expected %b", tag, pred_valid_o, ev);
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] ev, input logic [1:0] et);
        chk_v(tag, ev);
        tests++;
        assert (pred_taken_o === et) else begin
            fails++;
            $error("FAIL %s taken: observed %b expected %b", tag, pred_taken_o, et);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("reset", 2'b00, 2'b00);
        rst_ni = 1'b1;
`ifdef BHT_GLOBAL_HIST_EN
        upd(64'h8000_0000, 1'b1);
        look(64'h8000_0000);
        chk("hist_row1", 2'b00, 2'b00);
        look(64'h8000_0004);
        chk("hist_row0", 2'b01, 2'b01);
`else
        look(64'h8000_0000);
        chk("empty_lookup", 2'b00, 2'b00);
        upd(64'h8000_0000, 1'b1);
        look(64'h8000_0000);
        chk("t1_ctr10", 2'b01, 2'b01);
        upd(64'h8000_0000, 1'b1);
        look(64'h8000_0000);
        chk("t2_ctr11", 2'b01, 2'b01);
        upd(64'h8000_0000, 1'b1);
        upd(64'h8000_0000, 1'b0);
        look(64'h8000_0000);
        chk("sat_hi_ctr10", 2'b01, 2'b01);
        upd(64'h8000_0000, 1'b0);
        look(64'h8000_0000);
        chk("nt_ctr01", 2'b01, 2'b00);
        upd(64'h8000_0000, 1'b0);
        upd(64'h8000_0000, 1'b0);
        look(64'h8000_0000);
        chk("nt_ctr00", 2'b01, 2'b00);
        upd(64'h8000_0000, 1'b1);
        look(64'h8000_0000);
        chk("sat_lo_ctr01", 2'b01, 2'b00);
        upd(64'h8000_0002, 1'b1);
        look(64'h8000_0000);
        chk("slot1", 2'b11, 2'b10);
        look(64'h8000_0100);
        chk("alias", 2'b11, 2'b10);
        tick();
        chk("no_lookup", 2'b00, 2'b00);
        update_valid_i = 1'b1;
        update_pc_i    = 64'h8000_0010;
        update_taken_i = 1'b1;
        look(64'h8000_0010);
        update_valid_i = 1'b0;
        chk("rbw_same_cycle", 2'b00, 2'b00);
        look(64'h8000_0010);
        chk("rbw_next_cycle", 2'b01, 2'b01);
        flush_i = 1'b1;
        update_valid_i = 1'b1;
        update_pc_i    = 64'h8000_0020;
        update_taken_i = 1'b1;
        look(64'h8000_0000);
        update_valid_i = 1'b0;
        flush_i = 1'b0;
        chk_v("flush_lookup", 2'b00);
        look(64'h8000_0000);
        chk_v("flush_row0", 2'b00);
        look(64'h8000_0010);
        chk_v("flush_row4", 2'b00);
        look(64'h8000_0020);
        chk("flush_upd_dropped", 2'b00, 2'b00);
        debug_mode_i = 1'b1;
        upd(64'h8000_0020, 1'b1);
        debug_mode_i = 1'b0;
        look(64'h8000_0020);
        chk("debug_no_train", 2'b00, 2'b00);
        upd(64'h8000_0020, 1'b1);
        look(64'h8000_0020);
        chk("train_after_debug", 2'b01, 2'b01);
        rst_ni = 1'b0;
        upd(64'h8000_0030, 1'b1);
        rst_ni = 1'b1;
        look(64'h8000_0030);
        chk("reset_drops_upd", 2'b00, 2'b00);
        look(64'h8000_0020);
        chk("reset_clears", 2'b00, 2'b00);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
